// File: rtl/operand_sequencer.sv
// Registered operand sequencer: captures one decoded instruction via valid/ready and
// issues its op1/op2 operands to the ALU as one or more BEAT_LANES-wide beats.
module operand_sequencer #(
  parameter int LANES      = 16,
  parameter int LANE_W     = 16,
  parameter int BEAT_LANES = 16,
  localparam int NBEATS    = LANES / BEAT_LANES,
  localparam int BW        = (NBEATS > 1) ? $clog2(NBEATS) : 1
) (
  input  logic                         clk,
  input  logic                         rst,
  input  logic                         in_valid,
  output logic                         in_ready,
  input  logic [3:0]                   functype,
  input  logic [LANES*LANE_W-1:0]      vectorData1,
  input  logic [LANES*LANE_W-1:0]      vectorData2,
  input  logic [LANE_W-1:0]            scalarData1,
  input  logic [7:0]                   immediate,
  input  logic [5:0]                   offset,
  input  logic [LANE_W-1:0]            PC,
  output logic                         out_valid,
  input  logic                         out_ready,
  output logic [BEAT_LANES*LANE_W-1:0] op1,
  output logic [BEAT_LANES*LANE_W-1:0] op2,
  output logic [3:0]                   out_func,
  output logic [BW-1:0]                out_beat,
  output logic                         out_last
);

  localparam int VW = LANES * LANE_W;
  localparam int OW = BEAT_LANES * LANE_W;

  typedef enum logic {IDLE, ISSUE} state_t;

  state_t            r_state;
  logic [3:0]        r_func;
  logic [BW-1:0]     r_beat;
  logic              r_last;
  logic [OW-1:0]     r_op1, r_op2;
  logic [VW-1:0]     r_vd1, r_vd2;
  logic [LANE_W-1:0] r_sd1, r_pc;
  logic [7:0]        r_imm;
  logic [5:0]        r_off;

  logic              w_fire, w_adv, w_multi, w_last;
  logic [3:0]        w_func;
  logic [BW-1:0]     w_beat;
  logic [VW-1:0]     w_vd1, w_vd2;
  logic [LANE_W-1:0] w_sd1, w_pc;
  logic [7:0]        w_imm;
  logic [5:0]        w_off;
  logic [OW-1:0]     w_op1, w_op2;
  int unsigned       w_boff;

  assign w_adv    = (r_state == ISSUE) && out_ready;
  assign in_ready = (r_state == IDLE) || (w_adv && r_last);
  assign w_fire   = in_valid && in_ready;

  // The next beat comes straight from the ports on accept, otherwise from the holding registers.
  always_comb begin
    w_func = w_fire ? functype    : r_func;
    w_vd1  = w_fire ? vectorData1 : r_vd1;
    w_vd2  = w_fire ? vectorData2 : r_vd2;
    w_sd1  = w_fire ? scalarData1 : r_sd1;
    w_pc   = w_fire ? PC          : r_pc;
    w_imm  = w_fire ? immediate   : r_imm;
    w_off  = w_fire ? offset      : r_off;
    w_beat = w_fire ? '0 : BW'(r_beat + 1'b1);
  end

  assign w_multi = (NBEATS > 1) && (w_func <= 4'd2);
  assign w_last  = !w_multi || (w_beat == BW'(NBEATS - 1));

  always_comb begin
    w_op1  = '0;
    w_op2  = '0;
    w_boff = (NBEATS > 1) ? int'(w_beat) * OW : 0;
    case (w_func)
      4'h0, 4'h1: begin
        w_op1 = w_vd1[w_boff +: OW];
        w_op2 = w_vd2[w_boff +: OW];
      end
      4'h2: begin
        w_op1 = w_vd1[w_boff +: OW];
        w_op2 = {BEAT_LANES{w_sd1}};
      end
      4'h3, 4'h4, 4'h5: begin
        w_op1[LANE_W-1:0] = w_sd1;
        w_op2[LANE_W-1:0] = {{(LANE_W-6){w_off[5]}}, w_off};
      end
      4'h6, 4'h7: begin
        w_op1[LANE_W-1:0] = w_sd1;
        w_op2[LANE_W-1:0] = LANE_W'(w_imm);
      end
      4'h8: begin
        w_op1[LANE_W-1:0] = w_pc;
        w_op2[LANE_W-1:0] = {{(LANE_W-8){w_imm[7]}}, w_imm};
      end
      default: ;
    endcase
  end

  always_ff @(posedge clk or posedge rst) begin
    if (rst) begin
      r_state <= IDLE;
      r_func  <= '0;
      r_beat  <= '0;
      r_last  <= 1'b0;
      r_op1   <= '0;
      r_op2   <= '0;
      r_vd1   <= '0;
      r_vd2   <= '0;
      r_sd1   <= '0;
      r_pc    <= '0;
      r_imm   <= '0;
      r_off   <= '0;
    end else begin
      if (w_fire && functype != 4'hF) begin
        r_state <= ISSUE;
        r_func  <= functype;
        r_beat  <= '0;
        r_last  <= w_last;
        r_op1   <= w_op1;
        r_op2   <= w_op2;
        r_vd1   <= vectorData1;
        r_vd2   <= vectorData2;
        r_sd1   <= scalarData1;
        r_pc    <= PC;
        r_imm   <= immediate;
        r_off   <= offset;
      end else if (w_fire || (w_adv && r_last)) begin
        // NOP accept or final beat gone with nothing new: drop back to IDLE.
        r_state <= IDLE;
      end else if (w_adv) begin
        r_beat <= w_beat;
        r_last <= w_last;
        r_op1  <= w_op1;
        r_op2  <= w_op2;
      end
    end
  end

  assign out_valid = (r_state == ISSUE);
  assign op1       = r_op1;
  assign op2       = r_op2;
  assign out_func  = r_func;
  assign out_beat  = r_beat;
  assign out_last  = r_last;

endmodule

// File: tb/tb_operand_sequencer.sv
// Directed bench for operand_sequencer: one default-width instance and one 4-lane-beat instance.
module tb_operand_sequencer;

  logic         clk = 1'b0;
  logic         rst;
  logic [3:0]   functype;
  logic [255:0] vd1, vd2;
  logic [15:0]  sd1, pc;
  logic [7:0]   imm;
  logic [5:0]   off;

  logic         iv16, rdy16, ov16, ordy16, last16;
  logic [255:0] op1_16, op2_16;
  logic [3:0]   func16;
  logic [0:0]   beat16;

  logic         iv4, rdy4, ov4, ordy4, last4;
  logic [63:0]  op1_4, op2_4;
  logic [3:0]   func4;
  logic [1:0]   beat4;

  int n_chk = 0;
  int n_err = 0;

  always #5 clk = ~clk;

  operand_sequencer dut16 (
    .clk(clk), .rst(rst), .in_valid(iv16), .in_ready(rdy16), .functype(functype),
    .vectorData1(vd1), .vectorData2(vd2), .scalarData1(sd1), .immediate(imm),
    .offset(off), .PC(pc), .out_valid(ov16), .out_ready(ordy16), .op1(op1_16),
    .op2(op2_16), .out_func(func16), .out_beat(beat16), .out_last(last16)
  );

  operand_sequencer #(.LANES(16), .LANE_W(16), .BEAT_LANES(4)) dut4 (
    .clk(clk), .rst(rst), .in_valid(iv4), .in_ready(rdy4), .functype(functype),
    .vectorData1(vd1), .vectorData2(vd2), .scalarData1(sd1), .immediate(imm),
    .offset(off), .PC(pc), .out_valid(ov4), .out_ready(ordy4), .op1(op1_4),
    .op2(op2_4), .out_func(func4), .out_beat(beat4), .out_last(last4)
  );

  typedef struct {
    logic [3:0]  f;
    logic [15:0] sd1;
    logic [15:0] pc;
    logic [7:0]  imm;
    logic [5:0]  off;
    logic [15:0] e1;
    logic [15:0] e2;
  } vec_t;

  vec_t tbl[8];

  task automatic chk(input string name, input logic [255:0] act, input logic [255:0] exp);
    n_chk++;
    if (act !== exp) begin
      n_err++;
      $display("FAIL %s: got %0h expected %0h", name, act, exp);
    end
  endtask

  // n consecutive 16-bit lanes with values base+first, base+first+1, ...
  function automatic logic [255:0] lanes(input int base, input int first, input int n);
    logic [255:0] r;
    r = '0;
    for (int k = 0; k < n; k++) r[k*16 +: 16] = 16'(base + first + k);
    return r;
  endfunction

  task automatic tick();
    @(posedge clk);
    #1;
  endtask

  initial begin
    rst = 1'b1; iv16 = 0; iv4 = 0; ordy16 = 1; ordy4 = 1;
    functype = 4'hF; sd1 = '0; pc = '0; imm = '0; off = '0;
    for (int i = 0; i < 16; i++) begin
      vd1[i*16 +: 16] = 16'(i);
      vd2[i*16 +: 16] = 16'(16'h100 + i);
    end

    tbl[0] = '{4'h3, 16'h1234, 16'h0000, 8'h00, 6'h05,    16'h1234, 16'h0005};
    tbl[1] = '{4'h4, 16'h1000, 16'h0000, 8'h00, 6'b111110, 16'h1000, 16'hFFFE};
    tbl[2] = '{4'h5, 16'hABCD, 16'h0000, 8'h00, 6'b100000, 16'hABCD, 16'hFFE0};
    tbl[3] = '{4'h6, 16'h0001, 16'h0000, 8'hFF, 6'h00,    16'h0001, 16'h00FF};
    tbl[4] = '{4'h7, 16'h5555, 16'h0000, 8'h80, 6'h00,    16'h5555, 16'h0080};
    tbl[5] = '{4'h8, 16'h9999, 16'h0040, 8'h80, 6'h00,    16'h0040, 16'hFF80};
    tbl[6] = '{4'h8, 16'h9999, 16'h1234, 8'h7F, 6'h3F,    16'h1234, 16'h007F};
    tbl[7] = '{4'hA, 16'h7777, 16'h4321, 8'hFF, 6'h3F,    16'h0000, 16'h0000};

    #2;
    chk("reset ov4", 256'(ov4), 256'(0));
    chk("reset op1_4", 256'(op1_4), 256'(0));
    chk("reset op2_4", 256'(op2_4), 256'(0));
    chk("reset last/beat/func 4", 256'({last4, beat4, func4}), 256'(0));
    chk("reset rdy4", 256'(rdy4), 256'(1));
    chk("reset ov16", 256'(ov16), 256'(0));
    chk("reset rdy16", 256'(rdy16), 256'(1));
    @(negedge clk);
    rst = 1'b0;

    // Full-width VADD on the default instance
    @(negedge clk);
    functype = 4'h0; iv16 = 1;
    chk("vadd16 in_ready", 256'(rdy16), 256'(1));
    tick();
    iv16 = 0;
    chk("vadd16 ov", 256'(ov16), 256'(1));
    chk("vadd16 op1", op1_16, lanes(0, 0, 16));
    chk("vadd16 op2", op2_16, lanes(16'h100, 0, 16));
    chk("vadd16 last", 256'(last16), 256'(1));
    chk("vadd16 beat", 256'(beat16), 256'(0));
    chk("vadd16 in_ready while issuing", 256'(rdy16), 256'(1));
    tick();
    chk("vadd16 idle", 256'(ov16), 256'(0));

    // Single-beat table on the 4-lane instance
    for (int v = 0; v < 8; v++) begin
      @(negedge clk);
      functype = tbl[v].f; sd1 = tbl[v].sd1; pc = tbl[v].pc;
      imm = tbl[v].imm; off = tbl[v].off; iv4 = 1;
      chk($sformatf("tbl%0d in_ready", v), 256'(rdy4), 256'(1));
      tick();
      iv4 = 0;
      chk($sformatf("tbl%0d ov", v), 256'(ov4), 256'(1));
      chk($sformatf("tbl%0d op1", v), 256'(op1_4), 256'(tbl[v].e1));
      chk($sformatf("tbl%0d op2", v), 256'(op2_4), 256'(tbl[v].e2));
      chk($sformatf("tbl%0d last", v), 256'(last4), 256'(1));
      chk($sformatf("tbl%0d beat", v), 256'(beat4), 256'(0));
      chk($sformatf("tbl%0d func", v), 256'(func4), 256'(tbl[v].f));
      tick();
      chk($sformatf("tbl%0d idle", v), 256'(ov4), 256'(0));
    end

    // SMUL over 4 beats with a 2-cycle stall on beat 1
    @(negedge clk);
    functype = 4'h2; sd1 = 16'h0007; iv4 = 1; ordy4 = 1;
    tick();
    iv4 = 0;
    for (int b = 0; b < 4; b++) begin
      chk($sformatf("smul b%0d ov", b), 256'(ov4), 256'(1));
      chk($sformatf("smul b%0d beat", b), 256'(beat4), 256'(b));
      chk($sformatf("smul b%0d op1", b), 256'(op1_4), lanes(0, b*4, 4));
      chk($sformatf("smul b%0d op2", b), 256'(op2_4), 256'(64'h0007_0007_0007_0007));
      chk($sformatf("smul b%0d last", b), 256'(last4), 256'(b == 3));
      chk($sformatf("smul b%0d in_ready", b), 256'(rdy4), 256'(b == 3));
      if (b == 1) begin
        ordy4 = 0;
        for (int s = 0; s < 2; s++) begin
          tick();
          chk("smul stall beat", 256'(beat4), 256'(1));
          chk("smul stall op1", 256'(op1_4), lanes(0, 4, 4));
          chk("smul stall ov/last", 256'({ov4, last4}), 256'(2'b10));
          chk("smul stall in_ready", 256'(rdy4), 256'(0));
        end
        ordy4 = 1;
      end
      tick();
    end
    chk("smul done", 256'(ov4), 256'(0));

    // J then SLH back-to-back
    @(negedge clk);
    functype = 4'h8; pc = 16'h0040; imm = 8'h80; sd1 = 16'h2222; iv4 = 1;
    tick();
    chk("j op1", 256'(op1_4), 256'(16'h0040));
    chk("j op2", 256'(op2_4), 256'(16'hFF80));
    functype = 4'h7; imm = 8'h80;
    chk("j->slh in_ready", 256'(rdy4), 256'(1));
    tick();
    iv4 = 0;
    chk("slh ov", 256'(ov4), 256'(1));
    chk("slh func", 256'(func4), 256'(7));
    chk("slh op1", 256'(op1_4), 256'(16'h2222));
    chk("slh op2", 256'(op2_4), 256'(16'h0080));
    tick();
    chk("slh done", 256'(ov4), 256'(0));

    // NOP dropped, then SLL
    @(negedge clk);
    functype = 4'hF; iv4 = 1;
    tick();
    chk("nop no beat", 256'(ov4), 256'(0));
    chk("nop in_ready", 256'(rdy4), 256'(1));
    functype = 4'h6; sd1 = 16'h0005; imm = 8'h03;
    tick();
    iv4 = 0;
    chk("sll ov", 256'(ov4), 256'(1));
    chk("sll op1", 256'(op1_4), 256'(16'h0005));
    chk("sll op2", 256'(op2_4), 256'(16'h0003));
    tick();

    // Reset during beat 2 of a VDOT
    @(negedge clk);
    functype = 4'h1; iv4 = 1;
    tick();
    iv4 = 0;
    tick();
    tick();
    chk("vdot beat2 beat", 256'(beat4), 256'(2));
    chk("vdot beat2 op1", 256'(op1_4), lanes(0, 8, 4));
    chk("vdot beat2 op2", 256'(op2_4), lanes(16'h100, 8, 4));
    #2 rst = 1'b1;
    #1;
    chk("midrst ov", 256'(ov4), 256'(0));
    chk("midrst ops", 256'({op1_4, op2_4}), 256'(0));
    chk("midrst beat/last", 256'({beat4, last4}), 256'(0));
    chk("midrst in_ready", 256'(rdy4), 256'(1));
    @(negedge clk);
    rst = 1'b0;
    @(negedge clk);
    functype = 4'h1; iv4 = 1;
    tick();
    iv4 = 0;
    chk("vdot again ov", 256'(ov4), 256'(1));
    chk("vdot again beat", 256'(beat4), 256'(0));
    chk("vdot again op2", 256'(op2_4), lanes(16'h100, 0, 4));
    repeat (4) tick();
    chk("vdot again done", 256'(ov4), 256'(0));

    $display("Result: errors=%0d of %0d checks", n_err, n_chk);
    $finish;
  end

endmodule

// File: doc/operand_sequencer.md
Name: operand_sequencer

Overview:
- Registered, parametrised successor to the combinational operand picker in the execute front end.
- Captures one decoded instruction's source data through a valid/ready handshake and forms op1/op2 per function type.
- Issues vector operands to the ALU as one or more beats of BEAT_LANES lanes, so a narrow datapath can execute wide vector ops.
- Sits between register-file read and the ALU.

Parameters:
- LANES, 16, lanes per vector register.
- LANE_W, 16, bits per lane; also the width of scalars, PC and memory addresses.
- BEAT_LANES, 16, lanes issued per output beat. Must divide LANES. NBEATS = LANES/BEAT_LANES.

Ports:
- clk  in  1  clock.
- rst  in  1  reset, asynchronous, active-high.
- in_valid  in  1  instruction and operands valid.
- in_ready  out  1  sequencer can accept.
- functype  in  4  0 VADD, 1 VDOT, 2 SMUL, 3 SST, 4 VLD, 5 VST, 6 SLL, 7 SLH, 8 J, F NOP.
- vectorData1, vectorData2  in  LANES*LANE_W  vector sources.
- scalarData1  in  LANE_W  scalar source.
- immediate  in  8  immediate field.
- offset  in  6  address offset.
- PC  in  LANE_W  PC of the instruction.
- out_valid  out  1  beat valid.
- out_ready  in  1  ALU accepts beat.
- op1, op2  out  BEAT_LANES*LANE_W  beat operands.
- out_func  out  4  captured functype.
- out_beat  out  clog2(NBEATS), minimum 1  beat index.
- out_last  out  1  final beat of the instruction.

Behaviour:
- Reset, asynchronous: state IDLE, beat counter 0. out_valid, op1, op2, out_func, out_beat and out_last are 0. in_ready is 1.
- An instruction in flight at reset is discarded.

States:
- IDLE: in_ready=1, out_valid=0.
- ISSUE: out_valid=1.

Accept:
- Accept occurs on in_valid && in_ready.
- All inputs are registered into holding registers.
- Beat 0 appears on the outputs the cycle after accept (latency 1).

Handshake:
- A beat transfers on out_valid && out_ready.
- While out_valid && !out_ready, all outputs are held stable.
- in_ready = IDLE || (ISSUE && out_last && out_ready). A new instruction may be accepted in the same cycle the last beat transfers, giving back-to-back issue with no bubble.
- After a non-last beat transfers, the beat counter increments. The next beat is presented the following cycle.
- After the last beat transfers with no new accept, the block returns to IDLE.

Operand formation (lane k of beat b = vector lane b*BEAT_LANES+k; L0 = lane 0 of beat, other bits 0):
- VADD, VDOT: op1 = vectorData1 lanes, op2 = vectorData2 lanes. NBEATS beats.
- SMUL: op1 = vectorData1 lanes, op2 = scalarData1 broadcast to every lane. NBEATS beats.
- SST, VLD, VST: op1 L0 = scalarData1, op2 L0 = offset sign-extended to LANE_W. 1 beat.
- SLL, SLH: op1 L0 = scalarData1, op2 L0 = immediate zero-extended. 1 beat.
- J: op1 L0 = PC, op2 L0 = immediate sign-extended. 1 beat.
- Single-beat ops: out_beat=0, out_last=1.
- Undefined codes (9..E): op1 = op2 = 0, 1 beat, out_func passed through.
- NOP: accepted and dropped. No beat is issued and the block stays in/returns to IDLE, so in_ready remains 1.

Other rules:
- When NBEATS=1, every instruction is single-beat. Vector ops present all lanes at once with out_last=1.
- out_last = (beat counter == NBEATS-1) for multi-beat ops. The counter wraps to 0 on accept.
- No arithmetic is performed; widths are truncated/extended only as stated.

Test Plan:
- Defaults, VADD, vectorData1 lane i = i, vectorData2 lane i = 0x100+i, out_ready=1 -> one cycle later single beat with all 16 lanes, out_last=1, in_ready=1.
- LANES=16, BEAT_LANES=4, SMUL, scalarData1=0x0007, out_ready low for 2 cycles on beat 1 -> 4 beats with out_beat 0..3. op2 lanes all 0x0007. Beat 1 outputs held stable during the stall. out_last only on beat 3. in_ready=0 until the beat-3 transfer.
- VLD, scalarData1=0x1000, offset=6'b111110 -> op1 L0 = 0x1000, op2 L0 = 0xFFFE, upper bits 0, 1 beat.
- J, PC=0x0040, immediate=0x80, then SLH immediate=0x80 back-to-back -> J op2 L0 = 0xFF80, then SLH op2 L0 = 0x0080 on the next cycle with no bubble.
- NOP followed by SLL -> no beat for the NOP. SLL beat appears 1 cycle after its own accept.
- BEAT_LANES=4, assert rst during beat 2 of a VDOT -> outputs 0 immediately, in_ready=1. The next instruction issues normally from beat 0.
